// File: rtl/fetch_pkg.sv
// Shared types and constants for the LEGv8 instruction fetch stage.
package fetch_pkg;

    // Architectural NOP, placed in IF/ID whenever it holds no real instruction.
    localparam logic [31:0] NOP_INSTR   = 32'hD503201F;
    localparam int unsigned INSTR_BYTES = 4;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // Sequential PC step; wraps modulo 2^64.
    function automatic logic [63:0] next_pc(input logic [63:0] pc);
        return pc + 64'(INSTR_BYTES);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO buffering fetched words with their PCs.
// Flush has priority over push and pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 2,
    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1,
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  fetch_entry_t    push_data,
    input  logic            pop,
    input  logic            flush,
    output fetch_entry_t    head,
    output logic [CntW-1:0] count,
    output logic            empty,
    output logic            full
);

    fetch_entry_t    mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] rd_ptr_q;
    logic [PtrW-1:0] wr_ptr_q;
    logic [CntW-1:0] count_q;
    logic            do_push;
    logic            do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(FIFO_DEPTH - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign empty   = (count_q == '0);
    assign full    = (count_q == CntW'(FIFO_DEPTH));
    assign do_push = push && !flush && !full;
    assign do_pop  = pop && !flush && !empty;
    assign head    = mem_q[rd_ptr_q];
    assign count   = count_q;

    // Storage write; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// IF stage of the 5-stage LEGv8 pipeline. Issues in-order instruction memory
// reads under a credit limit, buffers returned words and feeds IF/ID.
// Optional: define IF_PERF_CNT_EN to add IFFetchCount / IFDropCount outputs.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH      = 2,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [63:0] RESET_PC        = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        IFStall,
    input  logic        IFRedirect,
    input  logic [63:0] IFRedirectPC,
    output logic        IMReqValid,
    input  logic        IMReqReady,
    output logic [63:0] IMReqAddr,
    input  logic        IMRspValid,
    input  logic [31:0] IMRspData,
    output logic [63:0] IDPC,
    output logic [31:0] IDInstr,
    output logic        IDValid
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] IFFetchCount,
    output logic [31:0] IFDropCount
`endif
);

    localparam int unsigned OutW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

    logic [63:0]     fetch_pc_q;
    logic [63:0]     rsp_pc_q;
    logic [OutW-1:0] outstanding_q;
    logic [OutW-1:0] outstanding_d;
    logic [OutW-1:0] drop_cnt_q;
    logic [63:0]     id_pc_q;
    logic [31:0]     id_instr_q;
    logic            id_valid_q;

    logic [31:0]     credit_used;
    logic            req_valid;
    logic            req_fire;
    logic            rsp_fire;
    logic            rsp_drop;
    logic            rsp_keep;
    logic            id_advance;
    logic            bypass;
    logic            id_load_valid;

    fetch_entry_t    rsp_entry;
    fetch_entry_t    fifo_head;
    logic            fifo_push;
    logic            fifo_pop;
    logic [CntW-1:0] fifo_count;
    logic            fifo_empty;
    logic            fifo_full;

    // Request credit, response classification and IF/ID steering.
    always_comb begin
        credit_used = 32'(outstanding_q) + 32'(fifo_count);
        // The full term is redundant with the credit check; kept as a guard.
        req_valid   = reset && !IFRedirect && !fifo_full
                      && (32'(outstanding_q) < MAX_OUTSTANDING)
                      && (credit_used < FIFO_DEPTH);
        req_fire    = req_valid && IMReqReady;
        // Responses with nothing outstanding are stale (pre-reset) and ignored.
        rsp_fire    = IMRspValid && (outstanding_q != '0);
        rsp_drop    = rsp_fire && (IFRedirect || (drop_cnt_q != '0));
        rsp_keep    = rsp_fire && !rsp_drop;
        id_advance  = !IFStall && !IFRedirect;
        bypass      = id_advance && fifo_empty && rsp_keep;
        fifo_push   = rsp_keep && !bypass;
        fifo_pop    = id_advance && !fifo_empty;
        id_load_valid = id_advance && (!fifo_empty || rsp_keep);
        outstanding_d = outstanding_q + OutW'(req_fire) - OutW'(rsp_fire);
    end

    assign rsp_entry  = '{pc: rsp_pc_q, instr: IMRspData};
    assign IMReqValid = req_valid;
    assign IMReqAddr  = fetch_pc_q;
    assign IDPC       = id_pc_q;
    assign IDInstr    = id_instr_q;
    assign IDValid    = id_valid_q;

    fetch_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (rsp_entry),
        .pop       (fifo_pop),
        .flush     (IFRedirect),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // Fetch/response PCs, in-flight count and the drop budget after redirects.
    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            outstanding_q <= outstanding_d;
            if (IFRedirect) begin
                fetch_pc_q <= IFRedirectPC;
                rsp_pc_q   <= IFRedirectPC;
                // Everything still in flight belongs to the abandoned path.
                drop_cnt_q <= outstanding_d;
            end else begin
                if (req_fire) begin
                    fetch_pc_q <= next_pc(fetch_pc_q);
                end
                if (rsp_keep) begin
                    rsp_pc_q <= next_pc(rsp_pc_q);
                end
                if (rsp_fire && (drop_cnt_q != '0)) begin
                    drop_cnt_q <= drop_cnt_q - OutW'(1);
                end
            end
        end
    end

    // IF/ID register: redirect flushes, stall holds, otherwise FIFO head or bypass.
    always_ff @(posedge clk) begin
        if (!reset) begin
            id_pc_q    <= '0;
            id_instr_q <= NOP_INSTR;
            id_valid_q <= 1'b0;
        end else if (IFRedirect) begin
            id_instr_q <= NOP_INSTR;
            id_valid_q <= 1'b0;
        end else if (!IFStall) begin
            if (!fifo_empty) begin
                id_pc_q    <= fifo_head.pc;
                id_instr_q <= fifo_head.instr;
                id_valid_q <= 1'b1;
            end else if (rsp_keep) begin
                id_pc_q    <= rsp_pc_q;
                id_instr_q <= IMRspData;
                id_valid_q <= 1'b1;
            end else begin
                id_instr_q <= NOP_INSTR;
                id_valid_q <= 1'b0;
            end
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_count_q;
    logic [31:0] drop_count_q;

    // Performance counters: valid IF/ID loads and discarded responses.
    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_count_q <= '0;
            drop_count_q  <= '0;
        end else begin
            if (id_load_valid) begin
                fetch_count_q <= fetch_count_q + 32'd1;
            end
            if (rsp_drop) begin
                drop_count_q <= drop_count_q + 32'd1;
            end
        end
    end

    assign IFFetchCount = fetch_count_q;
    assign IFDropCount  = drop_count_q;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized self-checking bench for instruction_fetch against a queue-based
// reference model of the fetch stream.
module tb_instruction_fetch;
    import fetch_pkg::*;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned MAXO  = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        IFStall;
    logic        IFRedirect;
    logic [63:0] IFRedirectPC;
    logic        IMReqValid;
    logic        IMReqReady;
    logic [63:0] IMReqAddr;
    logic        IMRspValid;
    logic [31:0] IMRspData;
    logic [63:0] IDPC;
    logic [31:0] IDInstr;
    logic        IDValid;
`ifdef IF_PERF_CNT_EN
    logic [31:0] IFFetchCount;
    logic [31:0] IFDropCount;
`endif

    always #5 clk = ~clk;

    instruction_fetch #(
        .FIFO_DEPTH      (DEPTH),
        .MAX_OUTSTANDING (MAXO),
        .RESET_PC        (64'h0)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .IFStall      (IFStall),
        .IFRedirect   (IFRedirect),
        .IFRedirectPC (IFRedirectPC),
        .IMReqValid   (IMReqValid),
        .IMReqReady   (IMReqReady),
        .IMReqAddr    (IMReqAddr),
        .IMRspValid   (IMRspValid),
        .IMRspData    (IMRspData),
        .IDPC         (IDPC),
        .IDInstr      (IDInstr),
`ifdef IF_PERF_CNT_EN
        .IDValid      (IDValid),
        .IFFetchCount (IFFetchCount),
        .IFDropCount  (IFDropCount)
`else
        .IDValid      (IDValid)
`endif
    );

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s @%0t: got %h, expected %h", tag, $time, obs, exp);
        end
    endtask

    // Reference model state.
    fetch_entry_t m_buf[$];        // words returned but not yet in IF/ID
    logic [63:0]  mem_pend[$];     // addresses accepted by memory, awaiting reply
    logic [63:0]  m_fetch_pc;
    logic [63:0]  m_rsp_pc;
    logic [63:0]  m_id_pc;
    logic [31:0]  m_id_instr;
    logic         m_id_valid;
    int           m_out;
    int           m_drop;
    int unsigned  m_fetches;
    int unsigned  m_drops;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return (a[31:0] * 32'd2654435761) ^ a[63:32] ^ 32'h0BAD_F00D;
    endfunction

    task automatic model_reset();
        m_buf.delete();
        m_fetch_pc = 64'h0;
        m_rsp_pc   = 64'h0;
        m_id_pc    = 64'h0;
        m_id_instr = NOP_INSTR;
        m_id_valid = 1'b0;
        m_out      = 0;
        m_drop     = 0;
        m_fetches  = 0;
        m_drops    = 0;
    endtask

    task automatic check_id();
        check_eq("id_valid", IDValid, m_id_valid);
        check_eq("id_pc", IDPC, m_id_pc);
        check_eq("id_instr", IDInstr, m_id_instr);
`ifdef IF_PERF_CNT_EN
        check_eq("fetch_count", IFFetchCount, m_fetches);
        check_eq("drop_count", IFDropCount, m_drops);
`endif
    endtask

    // One clock: drive inputs, check request side, advance model, check IF/ID.
    // rsp_mode: 0 = memory silent, 1 = reply whenever possible, 2 = random.
    task automatic step(input logic stall, input logic redir, input logic [63:0] rpc,
                        input logic ready, input int rsp_mode);
        logic         exp_valid;
        logic         acc;
        logic         fire;
        logic         drop;
        fetch_entry_t e;
        IFStall      = stall;
        IFRedirect   = redir;
        IFRedirectPC = rpc;
        IMReqReady   = ready;
        IMRspValid   = 1'b0;
        IMRspData    = $urandom;
        if (mem_pend.size() > 0 &&
            (rsp_mode == 1 || (rsp_mode == 2 && $urandom_range(0, 3) != 0))) begin
            IMRspValid = 1'b1;
            IMRspData  = mem_word(mem_pend[0]);
        end
        #1;
        exp_valid = !redir && (m_out < int'(MAXO)) && ((m_out + m_buf.size()) < int'(DEPTH));
        check_eq("req_valid", IMReqValid, exp_valid);
        if (exp_valid) check_eq("req_addr", IMReqAddr, m_fetch_pc);

        acc  = exp_valid && ready;
        fire = IMRspValid && (m_out > 0);
        if (IMRspValid) void'(mem_pend.pop_front());
        drop = fire && (m_drop > 0 || redir);
        if (fire && m_drop > 0) m_drop--;
        if (drop) m_drops++;
        if (acc) begin
            mem_pend.push_back(m_fetch_pc);
            m_fetch_pc = m_fetch_pc + 64'd4;
        end
        m_out = m_out + int'(acc) - int'(fire);
        if (fire && !drop) begin
            e.pc    = m_rsp_pc;
            e.instr = IMRspData;
            m_buf.push_back(e);
            m_rsp_pc = m_rsp_pc + 64'd4;
        end
        if (redir) begin
            m_fetch_pc = rpc;
            m_rsp_pc   = rpc;
            m_buf.delete();
            m_id_valid = 1'b0;
            m_id_instr = NOP_INSTR;
            m_drop     = m_out;
        end else if (!stall) begin
            if (m_buf.size() > 0) begin
                e          = m_buf.pop_front();
                m_id_pc    = e.pc;
                m_id_instr = e.instr;
                m_id_valid = 1'b1;
                m_fetches++;
            end else begin
                m_id_valid = 1'b0;
                m_id_instr = NOP_INSTR;
            end
        end
        @(posedge clk);
        #2;
        check_id();
    endtask

    task automatic do_reset(input int cycles, input bit keep_mem);
        reset        = 1'b0;
        IFStall      = 1'b0;
        IFRedirect   = 1'b0;
        IFRedirectPC = 64'h0;
        IMReqReady   = 1'b1;
        IMRspValid   = 1'b0;
        IMRspData    = 32'h0;
        repeat (cycles) begin
            #1;
            check_eq("req_valid_in_reset", IMReqValid, 1'b0);
            @(posedge clk);
            #2;
        end
        reset = 1'b1;
        model_reset();
        if (!keep_mem) mem_pend.delete();
        check_id();
    endtask

    initial begin
        logic [63:0] tgt;
        do_reset(2, 1'b0);

        // Zero-wait memory streaming from reset PC.
        repeat (10) step(1'b0, 1'b0, 64'h0, 1'b1, 1);

        // Stall held three cycles, then release.
        repeat (3) step(1'b1, 1'b0, 64'h0, 1'b1, 1);
        repeat (6) step(1'b0, 1'b0, 64'h0, 1'b1, 1);

        // Build two outstanding requests, then redirect.
        repeat (2) step(1'b0, 1'b0, 64'h0, 1'b1, 0);
        step(1'b0, 1'b1, 64'h100, 1'b0, 0);
        check_eq("redirect_addr", IMReqAddr, 64'h100);
        repeat (8) step(1'b0, 1'b0, 64'h0, 1'b1, 1);

        // Memory not ready for four cycles.
        repeat (4) step(1'b0, 1'b0, 64'h0, 1'b0, 1);
        repeat (4) step(1'b0, 1'b0, 64'h0, 1'b1, 1);

        // Fetch PC wrap at the top of the address space.
        step(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1);
        check_eq("wrap_pre", IMReqAddr, 64'hFFFF_FFFF_FFFF_FFFC);
        step(1'b0, 1'b0, 64'h0, 1'b1, 1);
        check_eq("wrap_post", IMReqAddr, 64'h0);
        repeat (6) step(1'b0, 1'b0, 64'h0, 1'b1, 1);

        // Drain, issue one request, reset, then deliver its late reply.
        for (int i = 0; i < 20 && (mem_pend.size() > 0 || m_out > 0); i++) begin
            step(1'b0, 1'b0, 64'h0, 1'b0, 1);
        end
        check_eq("drained", m_out, 0);
        step(1'b0, 1'b0, 64'h0, 1'b1, 0);
        do_reset(1, 1'b1);
        step(1'b0, 1'b0, 64'h0, 1'b0, 1);
        repeat (6) step(1'b0, 1'b0, 64'h0, 1'b1, 1);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset(1, 1'b0);
            end else begin
                tgt = {$urandom, $urandom};
                if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
                step($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0, tgt,
                     $urandom_range(0, 3) != 0, 2);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- IF stage of the 5-stage LEGv8 pipeline.
- Issues in-order instruction memory reads from the fetch PC and buffers returned words with their PCs.
- Drives the IF/ID pipeline register (IDPC, IDInstr, IDValid) consumed by decode.
- Accepts stall from the hazard unit and taken-branch redirect (IDBranchPC) from decode.

Parameters:
- FIFO_DEPTH, 2: instruction buffer entries; also total credit for buffered plus in-flight words.
- MAX_OUTSTANDING, 2: maximum accepted but unanswered memory requests.
- RESET_PC, 64'h0: fetch PC after reset.

Ports:
- clk  in  1  single clock, all state updates on rising edge.
- reset  in  1  synchronous, active-low (0 = reset).
- IFStall  in  1  hold IF/ID register (load-use hazard).
- IFRedirect  in  1  taken branch resolved in ID this cycle.
- IFRedirectPC  in  64  branch target (IDBranchPC).
- IMReqValid  out  1  memory read request valid.
- IMReqReady  in  1  memory accepts request.
- IMReqAddr  out  64  request byte address.
- IMRspValid  in  1  read data valid; responses return in order, at least 1 cycle after acceptance.
- IMRspData  in  32  instruction word.
- IDPC  out  64  PC of instruction in IF/ID.
- IDInstr  out  32  instruction in IF/ID.
- IDValid  out  1  IF/ID holds a real instruction.

Behaviour:
- Reset (reset==0 at edge): fetchPC=RESET_PC, rspPC=RESET_PC, IDPC=0, IDInstr=NOP (32'hD503201F), IDValid=0, FIFO empty, outstanding=0, dropCnt=0; IMReqValid=0 during the reset cycle. Reset mid-transfer discards all in-flight state; later responses with outstanding==0 are ignored.
- Request: IMReqValid = !IFRedirect && outstanding<MAX_OUTSTANDING && (outstanding+fifoCount)<FIFO_DEPTH. IMReqAddr=fetchPC. On accept (valid&&ready), fetchPC+=4 modulo 2^64, outstanding++. The credit rule makes FIFO overflow impossible.
- Response: each IMRspValid decrements outstanding. If dropCnt>0, the word is discarded and dropCnt--. Otherwise {rspPC, IMRspData} enters the FIFO and rspPC+=4. Simultaneous accept and response: outstanding unchanged.
- IF/ID update, when !IFStall and no redirect:
  - FIFO non-empty: load head, IDValid=1, pop.
  - FIFO empty and a non-dropped response arrives: bypass the response directly to IF/ID (one-edge latency).
  - Otherwise: IDValid=0, IDInstr=NOP, IDPC unchanged.
- IFStall (no redirect): IF/ID holds. FIFO still fills and memory requests continue within credit.
- IFRedirect (overrides stall):
  - fetchPC=rspPC=IFRedirectPC.
  - FIFO flushed; IF/ID set to IDValid=0, IDInstr=NOP.
  - dropCnt = outstanding after this cycle's decrement, i.e. every word already in flight is dropped; a response arriving in the redirect cycle is also discarded.
  - No request is issued in the redirect cycle; the first target request is issued the next cycle.
- Back-to-back redirects: the last one wins; dropCnt is recomputed from current outstanding.
- IFRedirectPC is not required to be aligned; its low 2 bits pass through unchanged.

Optional Feature:
- IF_PERF_CNT_EN defined: adds outputs IFFetchCount[31:0] (IF/ID loads with IDValid=1) and IFDropCount[31:0] (discarded responses). Both are cleared on reset and wrap at 2^32.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package fetch_pkg:
  - NOP_INSTR = 32'hD503201F
  - INSTR_BYTES = 4
  - typedef fetch_entry_t {logic [63:0] pc; logic [31:0] instr;}
- Sub-module fetch_fifo: a FIFO_DEPTH-entry synchronous FIFO of fetch_entry_t with push, pop, flush, count, empty and full. Flush has priority over push.

Test Plan:
- Reset then zero-wait memory returning addr-derived words -> IDPC sequence 0,4,8,12 with IDValid=1 every cycle after fill; IMReqAddr strictly +4.
- IFStall held 3 cycles at IDPC=8 -> IDPC/IDInstr frozen; FIFO reaches 2, IMReqValid drops to 0; after release IDPC resumes 12,16 with nothing lost or duplicated.
- Redirect to 64'h100 with 2 requests outstanding -> both responses dropped, IDValid=0 for those cycles, next valid IDPC=64'h100 with the word fetched from 0x100.
- IMReqReady=0 for 4 cycles -> IMReqAddr stable, fetchPC unchanged, IDValid=0 once the FIFO drains.
- fetchPC=64'hFFFF_FFFF_FFFF_FFFC -> the next request address is 64'h0.
- Assert reset with one request outstanding, late response arrives -> ignored, first post-reset IDPC=RESET_PC; with IF_PERF_CNT_EN, IFDropCount=0 after reset.
